// File: rtl/tcdm36_rr_arbiter_if.sv
// Bundle of the N-master tagged TCDM request/response ports and the shared slave port.
// The arbiter uses modport slave; whatever drives the masters and the memory side uses modport master.
interface tcdm36_rr_arbiter_if #(
  parameter int N_MASTERS = 2
);
  logic [N_MASTERS-1:0]       m_req_i;
  logic [N_MASTERS-1:0][31:0] m_add_i;
  logic [N_MASTERS-1:0]       m_wen_i;
  logic [N_MASTERS-1:0][3:0]  m_be_i;
  logic [N_MASTERS-1:0][35:0] m_wdata_i;
  logic [N_MASTERS-1:0]       m_gnt_o;
  logic [N_MASTERS-1:0]       m_r_valid_o;
  logic [35:0]                m_r_rdata_o;
  logic                       m_r_opc_o;
  logic                       s_req_o;
  logic [31:0]                s_add_o;
  logic                       s_wen_o;
  logic [3:0]                 s_be_o;
  logic [35:0]                s_wdata_o;
  logic                       s_gnt_i;
  logic                       s_r_valid_i;
  logic [35:0]                s_r_rdata_i;
  logic                       s_r_opc_i;
  logic                       err_o;

  modport slave (
    input  m_req_i, m_add_i, m_wen_i, m_be_i, m_wdata_i,
    input  s_gnt_i, s_r_valid_i, s_r_rdata_i, s_r_opc_i,
    output m_gnt_o, m_r_valid_o, m_r_rdata_o, m_r_opc_o,
    output s_req_o, s_add_o, s_wen_o, s_be_o, s_wdata_o, err_o
  );

  modport master (
    output m_req_i, m_add_i, m_wen_i, m_be_i, m_wdata_i,
    output s_gnt_i, s_r_valid_i, s_r_rdata_i, s_r_opc_i,
    input  m_gnt_o, m_r_valid_o, m_r_rdata_o, m_r_opc_o,
    input  s_req_o, s_add_o, s_wen_o, s_be_o, s_wdata_o, err_o
  );
endinterface

// File: rtl/tcdm36_rr_arbiter.sv
// Round-robin arbiter sharing one tagged 36-bit TCDM slave port between N_MASTERS masters,
// with an in-order ID FIFO that steers each response back to the master that issued it.
module tcdm36_rr_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int DEPTH     = 2
) (
  input logic                     clk_i,
  input logic                     rst_i,
  tcdm36_rr_arbiter_if.slave      bus
);
  localparam int IDW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW  = $clog2(DEPTH + 1);

  logic [IDW-1:0]       ptr_r;
  logic [IDW-1:0]       fifo_r [DEPTH];
  logic [PW-1:0]        wr_ptr_r;
  logic [PW-1:0]        rd_ptr_r;
  logic [CW-1:0]        cnt_r;
  logic                 err_r;

  logic [IDW-1:0]       winner_s;
  logic                 full_s;
  logic                 hs_s;
  logic                 pop_s;
  logic [N_MASTERS-1:0] gnt_s;
  logic [N_MASTERS-1:0] rvalid_s;

  // First requester at or after ptr, wrapping; defaults to master 0 when idle.
  function automatic logic [IDW-1:0] rr_pick(input logic [N_MASTERS-1:0] req,
                                            input logic [IDW-1:0] ptr);
    logic [IDW-1:0] w;
    logic           found;
    int             idx;
    w     = '0;
    found = 1'b0;
    for (int k = 0; k < N_MASTERS; k++) begin
      idx = (int'(ptr) + k) % N_MASTERS;
      if (!found && req[idx]) begin
        w     = IDW'(idx);
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return w;
  endfunction

  function automatic logic [PW-1:0] fifo_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? PW'(0) : p + PW'(1);
  endfunction

  assign winner_s = rr_pick(bus.m_req_i, ptr_r);
  assign full_s   = (cnt_r == CW'(DEPTH));
  assign hs_s     = bus.s_req_o & bus.s_gnt_i;
  assign pop_s    = bus.s_r_valid_i & (cnt_r != CW'(0));

  assign bus.s_req_o   = (|bus.m_req_i) & ~full_s;
  assign bus.s_add_o   = bus.m_add_i[winner_s];
  assign bus.s_wen_o   = bus.m_wen_i[winner_s];
  assign bus.s_be_o    = bus.m_be_i[winner_s];
  assign bus.s_wdata_o = bus.m_wdata_i[winner_s];

  assign bus.m_r_rdata_o = bus.s_r_rdata_i;
  assign bus.m_r_opc_o   = bus.s_r_opc_i;
  assign bus.m_gnt_o     = gnt_s;
  assign bus.m_r_valid_o = rvalid_s;
  assign bus.err_o       = err_r;

  // One-hot grant to the current winner on handshake.
  always_comb begin
    gnt_s           = '0;
    gnt_s[winner_s] = hs_s;
  end

  // Response is routed to the ID at the FIFO head.
  always_comb begin
    rvalid_s = '0;
    if (pop_s) begin
      rvalid_s[fifo_r[rd_ptr_r]] = 1'b1;
    end else begin
      rvalid_s = '0;
    end
  end

  // Arbitration pointer, ID FIFO, occupancy and sticky protocol error.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ptr_r    <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      cnt_r    <= '0;
      err_r    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_r[i] <= '0;
      end
    end else begin
      if (hs_s) begin
        fifo_r[wr_ptr_r] <= winner_s;
        wr_ptr_r         <= fifo_inc(wr_ptr_r);
        ptr_r            <= (winner_s == IDW'(N_MASTERS - 1)) ? IDW'(0) : winner_s + IDW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= fifo_inc(rd_ptr_r);
      end
      // A response with nothing outstanding is a protocol violation.
      if (bus.s_r_valid_i && (cnt_r == CW'(0))) begin
        err_r <= 1'b1;
      end
      case ({hs_s, pop_s})
        2'b10:   cnt_r <= cnt_r + CW'(1);
        2'b01:   cnt_r <= cnt_r - CW'(1);
        default: cnt_r <= cnt_r;
      endcase
    end
  end
endmodule

// File: doc/tcdm36_rr_arbiter.md
# tcdm36_rr_arbiter

Round-robin arbiter sharing one tagged 36-bit TCDM slave port (DIFT extension: 32 data bits plus 4 tag bits) between N_MASTERS tagged TCDM masters. It sits upstream of the 36-to-32 bus converter or a tagged memory bank. It tracks up to DEPTH outstanding transactions in an in-order ID FIFO and routes each response back to the master that issued it.

## Interface
- N_MASTERS, 2, number of requesting masters (2..8)
- DEPTH, 2, max outstanding granted-but-unanswered transactions (1..4)
- clk_i  in  1  clock
- rst_i  in  1  synchronous reset, active-high
- m_req_i  in  N_MASTERS  per-master request
- m_add_i  in  N_MASTERS×32  per-master address
- m_wen_i  in  N_MASTERS  per-master write-enable-n (1 = read)
- m_be_i  in  N_MASTERS×4  per-master byte enables
- m_wdata_i  in  N_MASTERS×36  per-master write data; bits 35:32 are tags
- m_gnt_o  out  N_MASTERS  per-master grant
- m_r_valid_o  out  N_MASTERS  per-master response valid
- m_r_rdata_o  out  36  response data, broadcast to all masters
- m_r_opc_o  out  1  response error/opcode, broadcast
- s_req_o, s_add_o[31:0], s_wen_o, s_be_o[3:0], s_wdata_o[35:0]  out  shared slave request
- s_gnt_i  in  1  slave grant
- s_r_valid_i  in  1  slave response valid
- s_r_rdata_i  in  36  slave response data
- s_r_opc_i  in  1  slave response opcode
- err_o  out  1  sticky protocol error

## Operation
- State: rr pointer ptr (0..N_MASTERS-1), ID FIFO (DEPTH entries of clog2(N_MASTERS) bits), occupancy count cnt (0..DEPTH), err flag.
- full = (cnt == DEPTH). No bypass: a pop in the same cycle does not clear full for that cycle's request.
- Winner = first index i with m_req_i[i]=1, searching ptr, ptr+1, … and wrapping modulo N_MASTERS. Selection is combinational.
- s_req_o = |m_req_i & ~full. s_add_o, s_wen_o, s_be_o and s_wdata_o mux from the winner. When no master requests, they mux from master 0.
- m_gnt_o[winner] = s_gnt_i & s_req_o. All other grants are 0.
- Handshake (s_req_o & s_gnt_i):
  - push winner ID into the FIFO, cnt+1;
  - ptr ← (winner+1) mod N_MASTERS.
- ptr does not change without a handshake.
- Response (s_r_valid_i):
  - if cnt>0: m_r_valid_o[FIFO head]=1, pop, cnt-1;
  - if cnt==0: no m_r_valid_o is asserted, and err ← 1.
- Push and pop in the same cycle: cnt unchanged, and the FIFO read and write pointers both advance.
- m_r_rdata_o = s_r_rdata_i and m_r_opc_o = s_r_opc_i, both combinational pass-through.
- Tag bits 35:32 pass through unmodified in both directions.
- Masters hold req and payload stable until gnt, per the TCDM protocol. The winner may change while the slave stalls. That is legal because unserved masters keep requesting.
- err is cleared only by reset.

## Timing
- Reset (rst_i high at a rising edge): ptr=0, cnt=0, FIFO pointers=0, err_o=0. Outputs during reset are combinational: m_r_valid_o=0 when s_r_valid_i=0, and m_gnt_o follows s_gnt_i.
- Reset mid-operation discards all outstanding IDs. Any response arriving after reset sets err_o.
- Request-to-grant latency is 0 cycles, combinational through s_gnt_i.
- A response is accepted no earlier than 1 cycle after its grant. Response ordering is in-order, matching grant order.
- Throughput is 1 grant per cycle, provided cnt<DEPTH or the slave answers every cycle with DEPTH≥2.

## Test plan
- Single master 0 reads addr 0x1000, s_gnt_i=1, and the slave returns rdata 0xA_DEADBEEF on the next cycle. Required: m_gnt_o=01 in cycle 0; m_r_valid_o=01 and m_r_rdata_o=0xADEADBEEF in cycle 1; cnt returns to 0.
- Masters 0 and 1 request continuously, s_gnt_i=1, and the slave responds each cycle. Required: grants alternate 01,10,01,10 starting from master 0 after reset, and each m_r_valid_o matches the grant of the previous cycle.
- DEPTH=2, s_r_valid_i held 0, master 1 requests for 4 cycles. Required: exactly 2 grants, then s_req_o=0 and m_gnt_o=00. In the cycle a response arrives, s_req_o stays 0; it rises the following cycle.
- s_r_valid_i pulse with cnt=0. Required: m_r_valid_o=00 and err_o=1 from the next cycle, and err_o stays 1 until rst_i.
- s_gnt_i=0 for 3 cycles while master 1 requests, with ptr=1. Required: no push, ptr stays 1, s_add_o tracks master 1. Master 1 is granted when s_gnt_i rises.
- Two transactions outstanding, then rst_i pulsed for 1 cycle. Required: cnt=0 and ptr=0, and a late s_r_valid_i produces no m_r_valid_o and sets err_o.
